bus_master_8088: RTL and testbench

Minimum-mode 8088 bus-cycle initiator. Accepts single-byte memory or I/O read/write requests from a local command port and drives the multiplexed 8088 bus: AD, A, ALE, IOM, RD, WR, DTR and DEN, through T1–T2–T3–(TW)–T4. It is the initiator counterpart to the existing memory/IO responder FSMs. It plugs into the same 8282 latch, 8286 transceiver and chip-select fabric as the Intel8088 model, so the top-level bench can run directed bus traffic without the CPU model.

---
 rtl/bus8088_pkg.sv | 18 +
 rtl/bus_master_8088.sv | 152 +++++++++++++++
 tb/tb_bus_master_8088.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus8088_pkg.sv
// Shared definitions for the 8088 minimum-mode bus initiator and the memory/IO responders.
package bus8088_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StT1,
    StT2,
    StT3,
    StTw,
    StT4
  } bus_state_t;

  localparam int unsigned T_STATES = 4;

  localparam logic IOM_MEM = 1'b0;
  localparam logic IOM_IO  = 1'b1;

endpackage

// File: rtl/bus_master_8088.sv
// Minimum-mode 8088 bus-cycle initiator: turns single-byte command-port requests into
// T1-T2-T3-(TW)-T4 bus cycles on the multiplexed AD/A bus with registered strobes.
module bus_master_8088
  import bus8088_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        req_io,
  input  logic        req_wr,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  input  logic        READY,
  inout  wire  [7:0]  AD,
  output logic [11:0] A,
  output logic        ALE,
  output logic        IOM,
  output logic        RD,
  output logic        WR,
  output logic        DTR,
  output logic        DEN
);

  localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);

  bus_state_t      state_q, state_d;
  logic [CntW-1:0] wcnt_q;
  logic            wr_q;
  logic [7:0]      wdata_q;
  logic            ad_oe_q;
  logic [7:0]      ad_out_q;
  logic            tmo;

  assign AD = ad_oe_q ? ad_out_q : 8'hzz;

  always_comb begin
    state_d = state_q;
    tmo     = 1'b0;
    unique case (state_q)
      StIdle: if (req) state_d = StT1;
      StT1:   state_d = StT2;
      StT2:   state_d = StT3;
      StT3:   state_d = READY ? StT4 : StTw;
      StTw: begin
        // READY wins over the timeout when both coincide
        if (READY) begin
          state_d = StT4;
        end else if (wcnt_q == CntW'(WAIT_LIMIT)) begin
          state_d = StT4;
          tmo     = 1'b1;
        end
      end
      StT4:   state_d = req ? StT1 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every bus pin is a flop output.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      wcnt_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= 8'h00;
      ad_oe_q  <= 1'b0;
      ad_out_q <= 8'h00;
      ack      <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= 8'h00;
      busy     <= 1'b0;
      A        <= 12'h000;
      ALE      <= 1'b0;
      IOM      <= IOM_MEM;
      RD       <= 1'b1;
      WR       <= 1'b1;
      DTR      <= 1'b0;
      DEN      <= 1'b1;
    end else begin
      state_q <= state_d;
      ack     <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;

      if ((state_q == StT3 || state_q == StTw) && READY && !wr_q) begin
        rdata <= AD;
      end

      unique case (state_d)
        StIdle: begin
          busy    <= 1'b0;
          ad_oe_q <= 1'b0;
          A       <= 12'h000;
          ALE     <= 1'b0;
          IOM     <= IOM_MEM;
          RD      <= 1'b1;
          WR      <= 1'b1;
          DTR     <= 1'b0;
          DEN     <= 1'b1;
        end
        StT1: begin
          ack      <= 1'b1;
          busy     <= 1'b1;
          wr_q     <= req_wr;
          wdata_q  <= req_wdata;
          ad_oe_q  <= 1'b1;
          ad_out_q <= req_addr[7:0];
          A        <= req_io ? {4'h0, req_addr[15:8]} : req_addr[19:8];
          ALE      <= 1'b1;
          IOM      <= req_io ? IOM_IO : IOM_MEM;
          DTR      <= req_wr;
          RD       <= 1'b1;
          WR       <= 1'b1;
          DEN      <= 1'b1;
        end
        StT2: begin
          ALE <= 1'b0;
          DEN <= 1'b0;
          if (wr_q) begin
            ad_out_q <= wdata_q;
            WR       <= 1'b0;
          end else begin
            ad_oe_q <= 1'b0;
            RD      <= 1'b0;
          end
        end
        StT3: ;
        StTw: begin
          if (state_q == StT3) wcnt_q <= '0;
          else                 wcnt_q <= wcnt_q + CntW'(1);
        end
        StT4: begin
          ad_oe_q <= 1'b0;
          RD      <= 1'b1;
          WR      <= 1'b1;
          DEN     <= 1'b1;
          done    <= 1'b1;
          err     <= tmo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_8088.sv
// Self-checking bench for bus_master_8088: directed vector table, hand sequences for
// reset and back-to-back cycles, and randomized traffic against a transaction-level model.
module tb_bus_master_8088;
  import bus8088_pkg::*;

  localparam int unsigned WL = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        req = 1'b0, req_io = 1'b0, req_wr = 1'b0, READY = 1'b1;
  logic [19:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        ack, done, err, busy, ALE, IOM, RD, WR, DTR, DEN;
  logic [7:0]  rdata;
  logic [11:0] A;
  wire  [7:0]  AD;

  int total = 0;
  int bad = 0;

  // Responder: 8282-style address latch, memory and I/O stores, READY wait generator
  logic [7:0]  rsp_mem [logic [19:0]];
  logic [7:0]  rsp_io  [logic [15:0]];
  logic [19:0] lat_addr = '0;
  logic        lat_io = 1'b0;
  logic [7:0]  rsp_byte = 8'h00;
  int          act = 0;
  int          wait_req = 0;

  assign AD = (RD === 1'b0) ? rsp_byte : 8'hzz;

  bus_master_8088 #(.WAIT_LIMIT(WL)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .req_io(req_io), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .done(done), .err(err),
    .rdata(rdata), .busy(busy), .READY(READY), .AD(AD), .A(A), .ALE(ALE), .IOM(IOM),
    .RD(RD), .WR(WR), .DTR(DTR), .DEN(DEN)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] rsp_get(input logic io, input logic [19:0] a);
    if (io) return rsp_io.exists(a[15:0]) ? rsp_io[a[15:0]] : 8'hFF;
    return rsp_mem.exists(a) ? rsp_mem[a] : 8'hFF;
  endfunction

  always @(negedge CLK) begin
    if (ALE === 1'b1) begin
      lat_addr = {A, AD};
      lat_io   = IOM;
      rsp_byte = rsp_get(lat_io, lat_addr);
    end
    if (WR === 1'b0) begin
      if (lat_io) rsp_io[lat_addr[15:0]] = AD;
      else        rsp_mem[lat_addr] = AD;
    end
    // READY is low for wait_req closing edges starting with the one that ends T3
    if (RD === 1'b0 || WR === 1'b0) begin
      act++;
      READY = (act >= 2 + wait_req);
    end else begin
      act = 0;
      READY = 1'b1;
    end
  end

  // Reference model: slave contents and last good read byte
  logic [7:0] ref_mem [logic [19:0]];
  logic [7:0] ref_io  [logic [15:0]];
  logic [7:0] model_rd;

  function automatic logic [7:0] ref_get(input logic io, input logic [19:0] a);
    if (io) return ref_io.exists(a[15:0]) ? ref_io[a[15:0]] : 8'hFF;
    return ref_mem.exists(a) ? ref_mem[a] : 8'hFF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic do_txn(input logic io, input logic wr, input logic [19:0] addr,
                        input logic [7:0] wd, input int waits,
                        output int len, output logic e, output logic [7:0] rd);
    int n;
    n = 0;
    wait_req  = waits;
    req       = 1'b1;
    req_io    = io;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    do begin
      @(negedge CLK);
      n++;
    end while (ack !== 1'b1 && n < 20);
    chk("ack", ack, 1);
    // Request fields are free to change once accepted
    req       = 1'b0;
    req_io    = ~io;
    req_wr    = ~wr;
    req_addr  = ~addr;
    req_wdata = ~wd;
    chk("t1_ale", ALE, 1);
    chk("t1_busy", busy, 1);
    chk("t1_a", A, io ? {4'h0, addr[15:8]} : addr[19:8]);
    chk("t1_ad", AD, addr[7:0]);
    chk("t1_iom_dtr", {IOM, DTR}, {io, wr});
    len = 1;
    while (done !== 1'b1 && len < 60) begin
      @(negedge CLK);
      len++;
      if (len == 2) begin
        chk("t2_ale_den", {ALE, DEN}, 2'b00);
        chk("t2_rd_wr", {RD, WR}, {wr, !wr});
        if (wr) chk("t2_ad", AD, wd);
      end
    end
    chk("done", done, 1);
    chk("t4_strobes", {RD, WR, DEN, ALE}, 4'b1110);
    chk("t4_hold", {IOM, DTR}, {io, wr});
    e  = err;
    rd = rdata;
  endtask

  typedef struct {
    logic        io;
    logic        wr;
    logic [19:0] addr;
    logic [7:0]  wd;
    int          waits;
    int          len;
    logic        e;
    logic [7:0]  rd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int         len;
    logic       e;
    logic [7:0] rd;
    int         ack_t[$];
    int         done_t[$];
    int         gaps;
    int         n;

    vecs[0] = '{1'b0, 1'b0, 20'h00005, 8'h00, 0,    4,  1'b0, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 20'hF1C02, 8'h3C, 0,    4,  1'b0, 8'hA5};
    vecs[2] = '{1'b0, 1'b0, 20'h80010, 8'h00, 3,    7,  1'b0, 8'h5A};
    vecs[3] = '{1'b0, 1'b0, 20'h00005, 8'h00, 17,   21, 1'b0, 8'hA5};
    vecs[4] = '{1'b0, 1'b0, 20'h80010, 8'h00, 1000, 21, 1'b1, 8'hA5};

    rsp_mem[20'h00005] = 8'hA5;
    rsp_mem[20'h80010] = 8'h5A;

    #1 RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_strobes", {ALE, RD, WR, DEN, DTR, IOM}, 6'b011100);
    chk("rst_a", A, 12'h000);
    chk("rst_ad_z", AD === 8'hzz, 1);
    chk("rst_flags", {ack, done, err, busy}, 4'b0000);
    chk("rst_rdata", rdata, 8'h00);
    RESET = 1'b0;
    @(negedge CLK);

    foreach (vecs[i]) begin
      do_txn(vecs[i].io, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].waits, len, e, rd);
      chk($sformatf("vec%0d_len", i), len, vecs[i].len);
      chk($sformatf("vec%0d_err", i), e, vecs[i].e);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
    end
    chk("io1_loc2", rsp_get(1'b1, 20'h01C02), 8'h3C);
    @(negedge CLK);
    chk("idle_after_tmo", {busy, RD, WR, DEN, ALE}, 5'b01110);
    chk("idle_ad_z", AD === 8'hzz, 1);

    // Randomized traffic in a region the directed vectors never touch
    model_rd = 8'hA5;
    for (int t = 0; t < 30; t++) begin
      logic        io, wr;
      logic [19:0] addr;
      logic [7:0]  wd;
      int          r, waits, exp_len;
      logic        exp_e;
      io    = 1'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      r     = $urandom_range(0, 7);
      addr  = io ? {4'($urandom), 16'h0300 + 16'(r)} : 20'h40000 + 20'(r);
      wd    = 8'($urandom);
      r     = $urandom_range(0, 9);
      waits = (r < 7) ? r % 4 : ((r == 7) ? WL + 1 : WL + 2);
      exp_e   = (waits > WL + 1);
      exp_len = 4 + (exp_e ? WL + 1 : waits);
      do_txn(io, wr, addr, wd, waits, len, e, rd);
      if (wr) begin
        if (io) ref_io[addr[15:0]] = wd;
        else    ref_mem[addr] = wd;
      end else if (!exp_e) begin
        model_rd = ref_get(io, addr);
      end
      chk($sformatf("rnd%0d_len", t), len, exp_len);
      chk($sformatf("rnd%0d_err", t), e, exp_e);
      chk($sformatf("rnd%0d_rdata", t), rd, model_rd);
    end

    // Reset asserted mid-T2 of a read
    wait_req = 0;
    req = 1'b1; req_io = 1'b0; req_wr = 1'b0; req_addr = 20'h00005;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (ack !== 1'b1 && n < 20);
    req = 1'b0;
    @(negedge CLK);
    chk("rst_mid_t2_rd", RD, 0);
    RESET = 1'b1;
    #1;
    chk("rst_mid_rd_hi", RD, 1);
    chk("rst_mid_ad_z", AD === 8'hzz, 1);
    chk("rst_mid_strobes", {ALE, WR, DEN, DTR, IOM, busy}, 6'b011000);
    chk("rst_mid_rdata", rdata, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("rst_mid_no_done", {done, ack, busy}, 3'b000);
    end
    RESET = 1'b0;
    @(negedge CLK);
    do_txn(1'b0, 1'b0, 20'h00005, 8'h00, 0, len, e, rd);
    chk("post_rst_rdata", rd, 8'hA5);

    // Back-to-back write then read of the same byte with req held high
    @(negedge CLK);
    req = 1'b1; req_io = 1'b0; req_wr = 1'b1; req_addr = 20'h00100; req_wdata = 8'hC3;
    gaps = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      if (ack === 1'b1) begin
        ack_t.push_back(c);
        if (ack_t.size() == 1) begin
          req_wr = 1'b0;
          req_wdata = 8'h00;
        end else begin
          req = 1'b0;
        end
      end
      if (done === 1'b1) done_t.push_back(c);
      if (ack_t.size() >= 1 && done_t.size() < 2 && busy !== 1'b1) gaps++;
    end
    chk("b2b_acks", ack_t.size(), 2);
    chk("b2b_dones", done_t.size(), 2);
    chk("b2b_ack_gap", (ack_t.size() == 2) ? ack_t[1] - ack_t[0] : -1, 4);
    chk("b2b_done_gap", (done_t.size() == 2) ? done_t[1] - done_t[0] : -1, 4);
    chk("b2b_first_done", (ack_t.size() >= 1 && done_t.size() >= 1) ?
        done_t[0] - ack_t[0] : -1, 3);
    chk("b2b_no_idle", gaps, 0);
    chk("b2b_readback", rdata, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
